serial_rx_fifo: RTL



---
 rtl/serial_rx_fifo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: receive buffer downstream of the async RX deserializer.
// Captures each byte on the one-cycle data-ready pulse into a show-ahead
// FIFO, tags packet boundaries from the end-of-packet pulse, and produces
// overrun, trigger-level and character-timeout status for the UART registers.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rx_data         byte from deserializer, valid while rx_data_ready is high
//   rx_data_ready   one-cycle write strobe
//   rx_endofpacket  one-cycle line-gap pulse; tags the newest buffered byte
//   rd_en           pop head entry (ignored when empty)
//   flush           synchronous FIFO clear
//   stat_rd         status-read strobe; clears overrun
//   trig_sel        trigger level: 0->1, 1->4, 2->8, 3->DEPTH-2
//   rd_data/rd_eop  head entry (combinational, show-ahead)
//   rd_valid        FIFO not empty
//   count           occupancy 0..DEPTH
//   full            count == DEPTH
//   overrun         sticky: a byte was dropped
//   irq_data        count >= trigger level
//   irq_timeout     end-of-packet seen with data still buffered
//   irq             irq_data | irq_timeout | overrun
module serial_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_ready,
  input  logic          rx_endofpacket,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          stat_rd,
  input  logic [1:0]    trig_sel,
  output logic [7:0]    rd_data,
  output logic          rd_eop,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          overrun,
  output logic          irq_data,
  output logic          irq_timeout,
  output logic          irq
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Entry layout: bit 8 = eop tag, bits 7:0 = data byte.
  logic [8:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        rd_valid_q, rd_valid_d;
  logic        full_q, full_d;
  logic        overrun_q, overrun_d;
  logic        irq_timeout_q, irq_timeout_d;
  logic        irq_data_q, irq_data_d;

  logic        do_pop, do_wr, do_drop, do_tag;
  logic [31:0] trig_level;
  logic [AW-1:0] wr_idx, rd_idx, last_idx;

  assign wr_idx   = wr_ptr_q[AW-1:0];
  assign rd_idx   = rd_ptr_q[AW-1:0];
  assign last_idx = wr_idx - IDX_ONE;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // byte when it is being read. Flush discards the byte without an overrun.
  assign do_pop  = rd_en && rd_valid_q;
  assign do_wr   = rx_data_ready && (!full_q || do_pop) && !flush;
  assign do_drop = rx_data_ready && full_q && !do_pop && !flush;
  // The tag lands on the entry written before this cycle; it is lost if that
  // entry is the one being popped (it is then the only entry).
  assign do_tag  = rx_endofpacket && rd_valid_q && !flush &&
                   !(do_pop && count_q == CNT_ONE);

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Occupancy flags come straight from the next pointers so they can never
    // disagree with them.
    count_d    = wr_ptr_d - rd_ptr_d;
    rd_valid_d = (wr_ptr_d != rd_ptr_d);
    full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                 (wr_ptr_d[AW] != rd_ptr_d[AW]);

    case (trig_sel)
      2'd0:    trig_level = 32'd1;
      2'd1:    trig_level = 32'd4;
      2'd2:    trig_level = 32'd8;
      default: trig_level = 32'(DEPTH - 2);
    endcase
    irq_data_d = (32'(count_d) >= trig_level);

    // Set wins over the status-read clear.
    if (do_drop)      overrun_d = 1'b1;
    else if (stat_rd) overrun_d = 1'b0;
    else              overrun_d = overrun_q;

    // Clear (pop or flush) wins over a simultaneous end-of-packet.
    if (do_pop || flush)                    irq_timeout_d = 1'b0;
    else if (rx_endofpacket && rd_valid_d)  irq_timeout_d = 1'b1;
    else                                    irq_timeout_d = irq_timeout_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_valid_q    <= 1'b0;
      full_q        <= 1'b0;
      overrun_q     <= 1'b0;
      irq_timeout_q <= 1'b0;
      irq_data_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_valid_q    <= rd_valid_d;
      full_q        <= full_d;
      overrun_q     <= overrun_d;
      irq_timeout_q <= irq_timeout_d;
      irq_data_q    <= irq_data_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rd_valid-qualified outputs, and leaving it unreset lets it map to
  // plain RAM/register-file cells. The write index and tag index always differ.
  always_ff @(posedge clk) begin
    if (do_wr)  mem_q[wr_idx]    <= {1'b0, rx_data};
    if (do_tag) mem_q[last_idx][8] <= 1'b1;
  end

  assign rd_data     = mem_q[rd_idx][7:0];
  assign rd_eop      = mem_q[rd_idx][8];
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign overrun     = overrun_q;
  assign irq_data    = irq_data_q;
  assign irq_timeout = irq_timeout_q;
  assign irq         = irq_data_q | irq_timeout_q | overrun_q;

endmodule
